dcache_ctrl: RTL

Data-cache controller forming the MEM stage of the pipelined CPU. It sits directly upstream of the MEM/WB pipeline register: it supplies the load data and the memory-stall signal that freezes the pipeline. Internally it is a direct-mapped, write-back, write-allocate cache with 32-byte lines, backed by a 256-bit-wide off-chip memory with an enable/ack handshake.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_sram.sv | 75 +++++++
 rtl/dcache_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the data-cache controller: the controller state
// encoding, line/offset geometry and helpers that derive index and tag widths
// from the number of cache lines.
// -----------------------------------------------------------------------------
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_e;

    localparam int LINE_BITS      = 256;
    localparam int OFFSET_BITS    = 5;
    localparam int WORD_BITS      = 32;
    localparam int ADDR_BITS      = 32;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;

    // Number of address bits selecting a line.
    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Address bits left above index and offset.
    function automatic int tag_bits(input int num_lines);
        return ADDR_BITS - OFFSET_BITS - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// -----------------------------------------------------------------------------
// dcache_sram
// Storage for the direct-mapped cache: valid, dirty, tag and line data arrays.
// One combinational read port and one write port share the same line index.
//
// Ports
//   clk_i         clock
//   start_i       asynchronous active-low clear of valid and dirty bits
//   idx_i         line index for both read and write
//   rd_valid_o    valid bit of the indexed line
//   rd_dirty_o    dirty bit of the indexed line
//   rd_tag_o      stored tag of the indexed line
//   rd_line_o     stored data of the indexed line
//   word_we_i     write one 32-bit word and mark the line dirty
//   word_sel_i    word position within the line for word_we_i
//   word_data_i   word to write
//   line_we_i     full-line refill: data and tag written, valid=1, dirty=0
//   line_data_i   refill data
//   line_tag_i    refill tag
// Data and tag arrays are not reset; only valid/dirty are cleared.
// -----------------------------------------------------------------------------
module dcache_sram
    import dcache_pkg::*;
#(
    parameter  int NUM_LINES = 16,
    localparam int IDX_W     = index_bits(NUM_LINES),
    localparam int TAG_W     = tag_bits(NUM_LINES)
) (
    input  logic                 clk_i,
    input  logic                 start_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic                 rd_valid_o,
    output logic                 rd_dirty_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic [LINE_BITS-1:0] rd_line_o,
    input  logic                 word_we_i,
    input  logic [2:0]           word_sel_i,
    input  logic [WORD_BITS-1:0] word_data_i,
    input  logic                 line_we_i,
    input  logic [LINE_BITS-1:0] line_data_i,
    input  logic [TAG_W-1:0]     line_tag_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_line_o  = data_q[idx_i];

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            data_q[idx_i] <= line_data_i;
            tag_q[idx_i]  <= line_tag_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b0} +: WORD_BITS] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// MEM-stage data-cache controller: direct-mapped, write-back, write-allocate,
// 32-byte lines, backed by a 256-bit memory with an enable/ack handshake.
// Hits complete with no stall; misses optionally write back a dirty victim,
// refill the line, then service the held request in UPDATE.
//
// Ports
//   clk_i            clock
//   start_i          asynchronous active-low reset
//   cpu_addr_i       byte address (bits [1:0] ignored)
//   cpu_data_i       store data
//   cpu_MemRead_i    load request
//   cpu_MemWrite_i   store request (wins when both are set)
//   cpu_data_o       load data, 0 when there is no load hit
//   cpu_stall_o      pipeline stall
//   mem_addr_o       line address to memory
//   mem_data_o       write-back line data
//   mem_enable_o     memory request
//   mem_write_o      1 = write-back, 0 = refill
//   mem_data_i       refill data, valid with mem_ack_i
//   mem_ack_i        one-cycle completion pulse
//   hit_cnt_o        (DCACHE_STATS_EN only) IDLE hits
//   miss_cnt_o       (DCACHE_STATS_EN only) misses started from IDLE
//
// Optional feature macro: DCACHE_STATS_EN adds the hit/miss counters.
// -----------------------------------------------------------------------------
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic                 clk_i,
    input  logic                 start_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    localparam int IDX_W = index_bits(NUM_LINES);
    localparam int TAG_W = tag_bits(NUM_LINES);

    state_e state_q, state_d;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [2:0]           word_sel;
    logic                 req;
    logic                 is_load;
    logic                 hit;

    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic [WORD_BITS-1:0] rd_word;

    logic                 word_we;
    logic                 line_we;

    // Byte-within-word bits are not needed for word accesses.
    logic                 unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign req_idx  = cpu_addr_i[OFFSET_BITS +: IDX_W];
    assign req_tag  = cpu_addr_i[ADDR_BITS-1 -: TAG_W];
    assign word_sel = cpu_addr_i[4:2];
    assign req      = cpu_MemRead_i | cpu_MemWrite_i;
    // A simultaneous read+write is a store, so it never returns load data.
    assign is_load  = cpu_MemRead_i & ~cpu_MemWrite_i;
    assign hit      = rd_valid & (rd_tag == req_tag);
    assign rd_word  = rd_line[{word_sel, 5'b0} +: WORD_BITS];

    dcache_sram #(
        .NUM_LINES (NUM_LINES)
    ) u_sram (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .idx_i       (req_idx),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_line_o   (rd_line),
        .word_we_i   (word_we),
        .word_sel_i  (word_sel),
        .word_data_i (cpu_data_i),
        .line_we_i   (line_we),
        .line_data_i (mem_data_i),
        .line_tag_i  (req_tag)
    );

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        cpu_data_o  = '0;
        word_we     = 1'b0;
        line_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        word_we = cpu_MemWrite_i;
                        if (is_load) begin
                            cpu_data_o = rd_word;
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    line_we = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // The refilled line now matches the held request.
                if (hit) begin
                    word_we = cpu_MemWrite_i;
                    if (is_load) begin
                        cpu_data_o = rd_word;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory port is driven from the next state so it is registered and
    // already valid in the first cycle of WRITEBACK/ALLOCATE. The request and
    // victim are held stable, so the values do not change mid-transaction.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state_d)
                WRITEBACK: begin
                    mem_enable_o <= 1'b1;
                    mem_write_o  <= 1'b1;
                    mem_addr_o   <= {rd_tag, req_idx, {OFFSET_BITS{1'b0}}};
                    mem_data_o   <= rd_line;
                end
                ALLOCATE: begin
                    mem_enable_o <= 1'b1;
                    mem_write_o  <= 1'b0;
                    mem_addr_o   <= {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
                    mem_data_o   <= '0;
                end
                default: begin
                    mem_enable_o <= 1'b0;
                    mem_write_o  <= 1'b0;
                    mem_addr_o   <= '0;
                    mem_data_o   <= '0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Only IDLE decisions are counted; UPDATE completions are not hits.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == IDLE && req) begin
            if (hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
